// File: rtl/mips_cache_pkg.sv
// Shared types for the MIPS cache write-buffer: bus FSM states and buffer entry layout.
package mips_cache_pkg;

  localparam int WB_DEPTH_DEFAULT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wb_state_t;

  // One buffered store: word address, data and accumulated byte lanes.
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wb_entry_t;

endpackage

// File: rtl/mips_cache_wbuf_fifo.sv
// Write-buffer FIFO between the CPU store path and an Avalon write master.
// Stores to a word already buffered are merged in place, except into the head
// entry while it is being written on the bus. The bus side drains the head
// entry whenever the controller grants it.
module mips_cache_wbuf_fifo
  import mips_cache_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                addr,
  input  logic                       write_en,
  input  logic [31:0]                writedata,
  input  logic [3:0]                 byteenable,
  input  logic                       active,
  input  logic                       waitrequest,
  output logic                       addr_in_wb,
  output logic [31:0]                write_addr,
  output logic [31:0]                write_data,
  output logic [3:0]                 write_byteenable,
  output logic                       write_writeenable,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  wb_state_t         state;
  wb_entry_t         mem [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [DEPTH-1:0]  match;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW-1:0]     merge_idx;
  logic              merge_hit;
  logic              push;
  logic              pop;
  logic              store_ok;
  logic [CW-1:0]     count_nxt;

  // Overlay the enabled byte lanes of a new store onto a buffered entry.
  function automatic wb_entry_t merge_bytes(input wb_entry_t e, input logic [31:0] d,
                                            input logic [3:0] be);
    wb_entry_t r;
    r = e;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r.data[8*b +: 8] = d[8*b +: 8];
    end
    r.be = e.be | be;
    return r;
  endfunction

  // Address comparator per entry; also feeds the coherence output.
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign match[i] = vld[i] && (mem[i].addr == addr[31:2]);
  end

  assign addr_in_wb = |match;

  // Pick the merge target, skipping the head while it is on the bus.
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match[i] && !(state == WRITE && head == PW'(i))) begin
        merge_hit = 1'b1;
        merge_idx = PW'(i);
      end
    end
  end

  assign store_ok = write_en && (byteenable != 4'b0000);
  assign push     = store_ok && !merge_hit && !full;
  assign pop      = (state == WRITE) && !waitrequest;

  // Next occupancy: push and pop in the same cycle cancel out.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // Entry storage: new entry at tail, or byte merge into an existing entry.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= '{addr: addr[31:2], data: writedata, be: byteenable};
    end else if (store_ok && merge_hit) begin
      mem[merge_idx] <= merge_bytes(mem[merge_idx], writedata, byteenable);
    end
  end

  // Pointers, valid bits, flags and the bus FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      vld   <= '0;
    end else begin
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + PTR_ONE;
      end
      if (push) begin
        vld[tail] <= 1'b1;
        tail      <= tail + PTR_ONE;
      end
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
      empty <= (count_nxt == '0);
      case (state)
        IDLE:    if (active && !empty) state <= WRITE;
        WRITE:   if (!waitrequest && !(active && count > CNT_ONE)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus outputs present the head entry only while a write is in progress.
  always_comb begin
    write_writeenable = (state == WRITE);
    write_addr        = '0;
    write_data        = '0;
    write_byteenable  = '0;
    if (state == WRITE) begin
      write_addr       = {mem[head].addr, 2'b00};
      write_data       = mem[head].data;
      write_byteenable = mem[head].be;
    end
  end

endmodule

// File: tb/tb_mips_cache_wbuf_fifo.sv
// Directed bench for the write-buffer FIFO: single store, merge, fill/drain,
// bus stall, coherence lookup and reset during a write.
module tb_mips_cache_wbuf_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        write_en;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        active;
  logic        waitrequest;
  logic        addr_in_wb;
  logic [31:0] write_addr;
  logic [31:0] write_data;
  logic [3:0]  write_byteenable;
  logic        write_writeenable;
  logic        full;
  logic        empty;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  mips_cache_wbuf_fifo #(.DEPTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .addr              (addr),
    .write_en          (write_en),
    .writedata         (writedata),
    .byteenable        (byteenable),
    .active            (active),
    .waitrequest       (waitrequest),
    .addr_in_wb        (addr_in_wb),
    .write_addr        (write_addr),
    .write_data        (write_data),
    .write_byteenable  (write_byteenable),
    .write_writeenable (write_writeenable),
    .full              (full),
    .empty             (empty),
    .count             (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr = a; writedata = d; byteenable = be; write_en = 1'b1;
    tick();
    write_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; addr = '0; write_en = 1'b0; writedata = '0; byteenable = '0;
    active = 1'b0; waitrequest = 1'b0;
    tick(); tick();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_we", write_writeenable, 0);
    chk("rst_waddr", write_addr, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_wbe", write_byteenable, 0);
    rst = 1'b1;
    tick();

    // single store, drained immediately
    active = 1'b1;
    store(32'h100, 32'hDEADBEEF, 4'hF);
    chk("s_count", count, 1);
    chk("s_empty", empty, 0);
    tick();
    chk("s_we", write_writeenable, 1);
    chk("s_waddr", write_addr, 32'h100);
    chk("s_wdata", write_data, 32'hDEADBEEF);
    chk("s_wbe", write_byteenable, 4'hF);
    tick();
    chk("s_we_done", write_writeenable, 0);
    chk("s_empty_done", empty, 1);
    chk("s_count_done", count, 0);

    // merge two partial stores to the same word
    active = 1'b0;
    store(32'h200, 32'h000000AA, 4'b0001);
    store(32'h202, 32'h00CC0000, 4'b0100);
    chk("m_count", count, 1);
    active = 1'b1;
    tick();
    chk("m_waddr", write_addr, 32'h200);
    chk("m_wdata", write_data, 32'h00CC00AA);
    chk("m_wbe", write_byteenable, 4'b0101);
    active = 1'b0;
    tick();
    chk("m_empty", empty, 1);
    chk("m_we_done", write_writeenable, 0);

    // fill to full, fifth store dropped, then drain in order
    for (int i = 0; i < 4; i++) store(32'h400 + 32'(4*i), 32'(i + 1), 4'hF);
    chk("f_full", full, 1);
    chk("f_count", count, 4);
    store(32'h410, 32'h5, 4'hF);
    chk("f_count5", count, 4);
    addr = 32'h410; #1;
    chk("f_dropped", addr_in_wb, 0);
    active = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("f_we", write_writeenable, 1);
      chk("f_waddr", write_addr, 32'h400 + 32'(4*i));
      chk("f_wdata", write_data, 32'(i + 1));
      tick();
    end
    chk("f_empty", empty, 1);
    chk("f_notfull", full, 0);
    chk("f_we_done", write_writeenable, 0);

    // bus stall: outputs held, single pop afterwards
    active = 1'b0;
    store(32'h500, 32'h55, 4'hF);
    store(32'h504, 32'h66, 4'hF);
    waitrequest = 1'b1; active = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("w_we", write_writeenable, 1);
      chk("w_waddr", write_addr, 32'h500);
      chk("w_wdata", write_data, 32'h55);
      chk("w_count", count, 2);
      tick();
    end
    waitrequest = 1'b0; active = 1'b0;
    chk("w_waddr4", write_addr, 32'h500);
    chk("w_we4", write_writeenable, 1);
    tick();
    chk("w_count_pop", count, 1);
    chk("w_we_idle", write_writeenable, 0);
    active = 1'b1;
    tick();
    chk("w_waddr2", write_addr, 32'h504);
    chk("w_wdata2", write_data, 32'h66);
    tick();
    chk("w_empty", empty, 1);

    // coherence lookup
    active = 1'b0;
    store(32'h300, 32'h33, 4'hF);
    addr = 32'h302; #1;
    chk("c_hit", addr_in_wb, 1);
    addr = 32'h304; #1;
    chk("c_miss", addr_in_wb, 0);

    // reset in the middle of a write with three entries pending
    store(32'h308, 32'h34, 4'hF);
    store(32'h30C, 32'h35, 4'hF);
    chk("r_count3", count, 3);
    waitrequest = 1'b1; active = 1'b1;
    tick();
    chk("r_we", write_writeenable, 1);
    #1 rst = 1'b0;
    #1;
    chk("r_we_async", write_writeenable, 0);
    chk("r_count", count, 0);
    chk("r_empty", empty, 1);
    tick();
    rst = 1'b1; waitrequest = 1'b0; active = 1'b0;
    addr = 32'h300; #1;
    chk("r_flushed", addr_in_wb, 0);
    tick();
    chk("r_idle", write_writeenable, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_cache_wbuf_fifo.md
MIPS_CACHE_WBUF_FIFO -- requirements
Module: mips_cache_wbuf_fifo

Interface
REQ-001 The block SHALL take parameter DEPTH, default 4, meaning the number of write-buffer entries (power of two, >=2).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 addr  in  32  CPU store byte address.
REQ-006 write_en  in  1  CPU store request this cycle.
REQ-007 writedata  in  32  store data, byte lanes per byteenable.
REQ-008 byteenable  in  4  store byte lanes.
REQ-009 active  in  1  controller grant to start bus writes.
REQ-010 waitrequest  in  1  Avalon slave stall.
REQ-011 addr_in_wb  out  1  addr word matches any valid entry.
REQ-012 write_addr  out  32  Avalon write address, word-aligned.
REQ-013 write_data  out  32  Avalon write data.
REQ-014 write_byteenable  out  4  Avalon byte enables.
REQ-015 write_writeenable  out  1  Avalon write strobe.
REQ-016 full / empty / count  out  1/1/$clog2(DEPTH)+1  occupancy flags, all registered.

Function
REQ-017 Entries SHALL form a circular FIFO (head, tail, count); each entry holds word address addr[31:2], 32-bit data, and 4-bit byteenable.
REQ-018 Push: on write_en with byteenable!=0 and full=0 and no merge hit, the entry SHALL be written at tail, tail+1 mod DEPTH, count+1.
REQ-019 Merge: on write_en, if addr[31:2] matches a valid entry other than the head currently in WRITE, the block SHALL overwrite the enabled bytes of that entry and OR in byteenable, with count unchanged; merge is allowed while full.
REQ-020 Store with byteenable=0 SHALL be ignored; non-merging store while full SHALL be dropped (the controller stalls on full).
REQ-021 addr_in_wb SHALL be combinational: 1 iff addr[31:2] equals the address of any valid entry, including the head in flight.
REQ-022 The bus FSM SHALL have states IDLE and WRITE, with write_writeenable=1 exactly in WRITE.
REQ-023 IDLE->WRITE: next edge when active=1 and empty=0.
REQ-024 In WRITE, write_addr={head.addr,2'b00}, write_data and write_byteenable SHALL equal the head entry, held stable while waitrequest=1.
REQ-025 In WRITE with waitrequest=0, the block SHALL pop the head; it stays in WRITE if active=1 and count>1, else goes to IDLE.
REQ-026 A write in progress SHALL complete even if active falls; active only gates starting the next write.
REQ-027 Simultaneous push and pop SHALL leave count unchanged and the pointers both advance; full evaluates pre-pop, so a push while full is dropped even with a pop in the same cycle.
REQ-028 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow.

Reset
REQ-029 During rst=0: state=IDLE, head=tail=0, count=0, empty=1, full=0, write_writeenable=0, write_addr/write_data=0, write_byteenable=0, and all entries invalid.
REQ-030 Reset asserted mid-WRITE SHALL abort immediately and discard all entries.

Structure
REQ-031 The shared package mips_cache_pkg SHALL hold the wb_state_t enum (IDLE, WRITE), the wb_entry_t struct, and WB_DEPTH_DEFAULT.
REQ-032 The block SHALL be a single module with no sub-module; the address-match comparator array is inline generate logic.

Verification
REQ-033 Verification SHALL cover single store: addr=0x100, data=0xDEADBEEF, be=1111, active=1, waitrequest=0 -> one write cycle with write_addr=0x100, then empty=1.
REQ-034 Verification SHALL cover merge: stores 0x200 be=0001 data=0x000000AA, then 0x202 be=0100 data=0x00CC0000 with active=0 -> count=1, entry data 0x00CC00AA, be=0101.
REQ-035 Verification SHALL cover fill: 5 distinct stores with active=0 -> full=1 after 4, 5th dropped, count=4, then drain in order with active=1.
REQ-036 Verification SHALL cover waitrequest: waitrequest=1 for 3 cycles in WRITE -> outputs stable for 4 cycles and a single pop.
REQ-037 Verification SHALL cover coherence: entry 0x300 pending, addr=0x302 -> addr_in_wb=1; addr=0x304 -> 0.
REQ-038 Verification SHALL cover reset mid-write: rst=0 during WRITE with count=3 -> write_writeenable=0 asynchronously and count=0, empty=1.
